// File: rtl/bsg_manycore_ruche_link_buffer.sv
// Registered ruche-lane feedthrough: one circular-buffer FIFO per lane, E<->W swapped, ready_and or credit upstream.
// Optional per-lane stall statistics are enabled by defining BSG_MANYCORE_RUCHE_BUF_STATS_EN.
module bsg_manycore_ruche_link_buffer #(
  parameter int width_p        = 0,
  parameter int ruche_factor_p = 3,
  parameter int els_p          = 2,
  parameter int use_credits_p  = 0,
  localparam int data_w_lp     = (width_p > 0) ? width_p : 1
) (
  input  logic                                          clk_i,
  input  logic                                          reset_n_i,
  input  logic [ruche_factor_p-1:0][1:0]                v_i,
  input  logic [ruche_factor_p-1:0][1:0][data_w_lp-1:0] data_i,
  output logic [ruche_factor_p-1:0][1:0]                ready_o,
  output logic [ruche_factor_p-1:0][1:0]                v_o,
  output logic [ruche_factor_p-1:0][1:0][data_w_lp-1:0] data_o,
  input  logic [ruche_factor_p-1:0][1:0]                ready_i,
  output logic [ruche_factor_p-1:0][1:0]                overflow_o,
  output logic [ruche_factor_p-1:0][1:0][31:0]          stall_cnt_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam bit credit_mode_lp = (use_credits_p != 0);

  // Explicit wrap so non-power-of-2 depths stay in range.
  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar i = 0; i < ruche_factor_p; i++) begin : g_ruche
    for (genvar d = 0; d < 2; d++) begin : g_dir
      // Input lane [i][d] drains onto the opposite direction of the same ruche index.
      localparam int od = 1 - d;

      logic [data_w_lp-1:0] mem [els_p];
      logic [ptr_w_lp-1:0]  wr_ptr, rd_ptr;
      logic [cnt_w_lp-1:0]  count, count_next;
      logic                 not_full_q, credit_q, overflow_q;
      logic                 full, accept, enq, deq;

      assign full   = (count == cnt_w_lp'(els_p));
      assign deq    = (count != '0) & ready_i[i][od];
      assign accept = credit_mode_lp ? (~full | deq) : not_full_q;
      assign enq    = v_i[i][d] & accept;

      always_comb begin
        count_next = count;
        case ({enq, deq})
          2'b10:   count_next = count + 1'b1;
          2'b01:   count_next = count - 1'b1;
          default: count_next = count;
        endcase
      end

      // NOTE: state uses non-blocking assignments so every lane samples pre-edge values.
      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          wr_ptr     <= '0;
          rd_ptr     <= '0;
          count      <= '0;
          not_full_q <= 1'b0;
          credit_q   <= 1'b0;
          overflow_q <= 1'b0;
        end else begin
          if (enq) wr_ptr <= ptr_inc(wr_ptr);
          if (deq) rd_ptr <= ptr_inc(rd_ptr);
          count      <= count_next;
          not_full_q <= (count_next != cnt_w_lp'(els_p));
          credit_q   <= deq;
          overflow_q <= overflow_q | (v_i[i][d] & ~accept);
        end
      end

      // NOTE: payload storage has no reset; v_o (from count) qualifies every read.
      always_ff @(posedge clk_i) begin
        if (enq) mem[wr_ptr] <= data_i[i][d];
      end

      assign v_o[i][od]        = (count != '0);
      assign data_o[i][od]     = mem[rd_ptr];
      assign ready_o[i][d]     = credit_mode_lp ? credit_q : not_full_q;
      assign overflow_o[i][d]  = credit_mode_lp ? overflow_q : 1'b0;

`ifdef BSG_MANYCORE_RUCHE_BUF_STATS_EN
      logic [31:0] stall_q;
      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          stall_q <= '0;
        end else if ((count != '0) & ~ready_i[i][od] & (stall_q != 32'hFFFF_FFFF)) begin
          stall_q <= stall_q + 32'd1;
        end
      end
      assign stall_cnt_o[i][od] = stall_q;
`else
      assign stall_cnt_o[i][od] = '0;
`endif
    end
  end

endmodule

// File: doc/bsg_manycore_ruche_link_buffer.md
Name: bsg_manycore_ruche_link_buffer

Overview:
- Parametrised, registered feedthrough for horizontal ruche lanes. Replaces the plain wire feedthrough used in compute tiles for ruche indices ≥1.
- Each lane (ruche index i, direction W/E) gets an els_p-deep FIFO.
- Supports ready-valid or credit-based upstream flow control per instance.
- Sits between tiles or at pod edges, where long ruche wires need retiming without touching the router.

Parameters:
- width_p, 0 (invalid, must be set): lane payload width in bits (ruche_x link fwd or rev packet width).
- ruche_factor_p, 3: ruche channel count; lanes_lp = 2*ruche_factor_p, indexed [ruche_factor_p-1:0][E:W].
- els_p, 2: FIFO depth per lane; legal range 2..16.
- use_credits_p, 0: 0 = ready_and upstream handshake; 1 = credit-return upstream handshake.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- v_i  in  [ruche_factor_p-1:0][E:W]  input valid per lane.
- data_i  in  [ruche_factor_p-1:0][E:W][width_p]  input payload.
- ready_o  out  [ruche_factor_p-1:0][E:W]  ready_and (mode 0) or credit-return pulse (mode 1).
- v_o  out  [ruche_factor_p-1:0][E:W]  output valid.
- data_o  out  [ruche_factor_p-1:0][E:W][width_p]  output payload.
- ready_i  in  [ruche_factor_p-1:0][E:W]  downstream ready_and.
- overflow_o  out  [ruche_factor_p-1:0][E:W]  sticky credit-overflow flag (mode 1 only).
- stall_cnt_o  out  [ruche_factor_p-1:0][E:W][32]  optional statistics.

Behaviour:
- Lane mapping:
  - Output [i][E] is sourced from input [i][W] FIFO.
  - Output [i][W] is sourced from input [i][E] FIFO.
  - Lanes are fully independent; no arbitration between them.
- Reset (reset_n_i low, asynchronous): FIFOs empty, count=0, v_o=0, ready_o=0, overflow_o=0, stall_cnt_o=0. Values are held until the first clk_i edge after deassertion.
- Storage: circular buffer with wr_ptr, rd_ptr (clog2(els_p) bits each, wrap at els_p-1→0, also for non-power-of-2 els_p), and count of clog2(els_p+1) bits.
- Enqueue and dequeue:
  - enq = v_i & accept; deq = v_o & ready_i.
  - Enq and deq in the same cycle leave count unchanged.
- Latency: no bypass. Data is visible on v_o/data_o exactly 1 cycle after enq into an empty FIFO. Sustained throughput is 1 element/cycle per lane when els_p≥2.
- v_o = (count!=0); data_o = mem[rd_ptr]. Data is stable while v_o & ~ready_i.
- Mode 0 (ready_and):
  - ready_o = (count!=els_p), registered-state-derived; no combinational path from ready_i.
  - accept = ready_o. v_i while ready_o=0 is ignored, with no state change.
- Mode 1 (credit):
  - Upstream holds els_p credits after reset.
  - ready_o is a registered 1-cycle pulse, asserted the cycle after each deq (one pulse per element).
  - accept = (count!=els_p) | deq, i.e. full with simultaneous dequeue is accepted.
  - v_i when full with no deq: element dropped, pointers unchanged, overflow_o set sticky until reset.
  - In mode 0, overflow_o is constant 0.
- Reset mid-traffic: all in-flight elements are discarded; no credit pulses are issued for them.

Optional Feature:
- Macro: BSG_MANYCORE_RUCHE_BUF_STATS_EN.
- Defined: per-lane 32-bit counter of cycles with v_o & ~ready_i. It saturates at 32'hFFFF_FFFF and clears only on reset.
- Undefined: stall_cnt_o is tied to 0 and no counter flops are instantiated.

Test Plan:
- Mode 0, els_p=2, ruche_factor_p=3: drive lane [1][W] with 0xA5 for one cycle, ready_i=1 → v_o[1][E]=1 with data 0xA5 exactly 1 cycle later; every other v_o stays 0.
- Mode 0, back-pressure: ready_i[0][E]=0, stream 3 words on [0][W] → ready_o[0][W] drops after 2 accepted. Release ready_i → words emerge in order, with the third accepted once space frees.
- Mode 1, els_p=4: send 4 words with ready_i=0, then a 5th → overflow_o asserts and the 5th is dropped. Release ready_i → 4 words out, 4 ready_o pulses each 1 cycle after its deq.
- Mode 1, full FIFO + simultaneous v_i and deq → accepted, overflow_o stays 0, count stays 4.
- Assert reset_n_i low mid-burst (asynchronously, between edges) → v_o, ready_o, overflow_o go 0 immediately. After release, the first word has 1-cycle latency again.
- With the stats macro: hold v_o=1, ready_i=0 for 10 cycles → stall_cnt_o=10. Preload the counter near max → it saturates at 0xFFFFFFFF.
